design_1_wrapper: RTL and testbench
===================================

DESIGN_1_WRAPPER -- requirements
Module: design_1_wrapper

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port addr, input, 32 bits: host byte address; word index = addr[9:2] (256 x 32-bit words); addr[31:10] and addr[1:0] ignored, so addresses wrap.
REQ-004 SHALL have port data_in, input, 32 bits: host write data.
REQ-005 SHALL have port web, input, 4 bits: host byte write enables; bit k writes byte lane data_in[8k+7:8k]; 4'b0000 = no host access.
REQ-006 SHALL have port data_out, output, 32 bits: registered read data of word addr[9:2], one-cycle latency; may be left unconnected.
REQ-007 SHALL have port DEBUG_state, output, 6 bits: one-hot controller state.

Function
REQ-008 SHALL contain one single-port synchronous RAM of 256 x 32 bits with byte write enables and one-cycle read latency; contents SHALL NOT be cleared by rst.
REQ-009 Word 0 SHALL be the command word: bit0 = start, bits[2:1] = mode, bit31 = done.
REQ-010 Host access (web != 0) SHALL take priority on the RAM port; in that cycle the controller SHALL hold its state, counters and accumulator (stall).
REQ-011 Controller states and encodings: IDLE=6'h01, READ=6'h02, ACC=6'h04, WRITE=6'h08, STATUS=6'h10, DONE=6'h20; DEBUG_state SHALL equal the current state.
REQ-012 IDLE: each cycle, read word 0; when the returned data has bit0=1, latch mode=bits[2:1], clear index i and accumulator, go to READ.
REQ-013 READ: issue read of word 1+i, go to ACC.
REQ-014 ACC: capture read data; mode 0 and mode 3: acc = acc + data, modulo 2^32; mode 1: tmp = data; mode 2: tmp = ~data. Go to WRITE.
REQ-015 WRITE: modes 1 and 2 write tmp to word 16+i, all lanes; modes 0 and 3 write nothing except at i=7, which writes acc to word 9.
REQ-016 After WRITE: if i<7 then i=i+1 and go to READ, else go to STATUS.
REQ-017 STATUS SHALL write word 0 = 32'h8000_0000 | (mode<<1), which clears start and sets done, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE; because start is now 0, the operation does not retrigger.
REQ-019 Without host stalls, DEBUG_state SHALL show DONE 27 clock edges after the edge on which the host writes start=1 to word 0.
REQ-020 A host write of word 0 during an operation SHALL change memory only; the running operation continues with its latched mode.

Reset
REQ-021 On rst=1 the design SHALL immediately enter IDLE, with DEBUG_state=6'h01, i=0, acc=0, tmp=0, mode=0 and data_out=0.
REQ-022 Reset during an operation SHALL abort it with no further controller writes; on release the controller resumes polling word 0, which restarts the operation if start is still 1.

Verification
REQ-023 After reset, hold web=0 for 10 cycles -> DEBUG_state stays 6'h01.
REQ-024 Write words 1..8 = 1..8, then write addr=0, data_in=1, web=4'hF for 1 cycle -> DEBUG_state goes 6'h01, 6'h02, 6'h04, 6'h08 ..., reaches 6'h20; word 9 = 36 and word 0 = 32'h8000_0000.
REQ-025 Mode 1 (data_in=3) with words 1..8 = 32'hA0..A7 -> words 16..23 = 32'hA0..A7; word 0 = 32'h8000_0002.
REQ-026 Mode 2 (data_in=5) with word 1 = 0 -> word 16 = 32'hFFFF_FFFF.
REQ-027 Byte write: addr=4, web=4'b0010, data_in=32'h0000_AB00 over word 1 = 0 -> word 1 = 32'h0000_AB00; addr=32'h404 aliases word 1.
REQ-028 Assert rst while DEBUG_state=6'h08 -> DEBUG_state = 6'h01 immediately, without waiting for a clock edge; word 0 still has start=1, so the operation restarts after release.

Source files
------------

// File: rtl/design_1_wrapper.sv
// Word-RAM with a small sequencer: polls a command word, walks words 1..8,
// then accumulates, copies or inverts them and posts a done status.
module design_1_wrapper (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  web,
  output logic [31:0] data_out,
  output logic [5:0]  DEBUG_state
);

  localparam logic [5:0] S_IDLE   = 6'h01;
  localparam logic [5:0] S_READ   = 6'h02;
  localparam logic [5:0] S_ACC    = 6'h04;
  localparam logic [5:0] S_WRITE  = 6'h08;
  localparam logic [5:0] S_STATUS = 6'h10;
  localparam logic [5:0] S_DONE   = 6'h20;

  logic [31:0] mem [256];
  logic [5:0]  state, state_nxt;
  logic [2:0]  idx;
  logic [1:0]  mode;
  logic [31:0] acc, tmp, rd_q;
  logic        stall;
  logic [7:0]  ctrl_addr;
  logic        ctrl_we;
  logic [31:0] ctrl_wdata;
  logic [7:0]  waddr;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:10], addr[1:0]};
  assign stall       = |web;
  assign DEBUG_state = state;

  // host owns the write port whenever it drives any byte enable
  always_comb begin
    if (stall) begin
      waddr = addr[9:2];
      wen   = web;
      wdata = data_in;
    end else begin
      waddr = ctrl_addr;
      wen   = {4{ctrl_we}};
      wdata = ctrl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (wen[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out <= '0;
    else     data_out <= mem[addr[9:2]];
  end

  // controller read register freezes on stalls so a pending read survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_q <= '0;
    else if (!stall) rd_q <= mem[ctrl_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!stall) begin
      case (state)
        S_IDLE:   if (rd_q[0]) state_nxt = S_READ;
        S_READ:   state_nxt = S_ACC;
        S_ACC:    state_nxt = S_WRITE;
        S_WRITE:  state_nxt = (idx == 3'd7) ? S_STATUS : S_READ;
        S_STATUS: state_nxt = S_DONE;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // IDLE/STATUS/DONE address word 0, so the poll after DONE sees the new status
  always_comb begin
    ctrl_addr  = 8'd0;
    ctrl_we    = 1'b0;
    ctrl_wdata = '0;
    case (state)
      S_READ, S_ACC: ctrl_addr = {5'd0, idx} + 8'd1;
      S_WRITE: begin
        if (mode == 2'd1 || mode == 2'd2) begin
          ctrl_we    = 1'b1;
          ctrl_addr  = {5'd0, idx} + 8'd16;
          ctrl_wdata = tmp;
        end else if (idx == 3'd7) begin
          ctrl_we    = 1'b1;
          ctrl_addr  = 8'd9;
          ctrl_wdata = acc;
        end
      end
      S_STATUS: begin
        ctrl_we    = 1'b1;
        ctrl_wdata = {1'b1, 28'd0, mode, 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      mode <= '0;
      acc  <= '0;
      tmp  <= '0;
    end else if (!stall) begin
      case (state)
        S_IDLE: if (rd_q[0]) begin
          mode <= rd_q[2:1];
          idx  <= '0;
          acc  <= '0;
        end
        S_ACC: begin
          if (mode == 2'd0 || mode == 2'd3) acc <= acc + rd_q;
          else if (mode == 2'd1)            tmp <= rd_q;
          else                              tmp <= ~rd_q;
        end
        S_WRITE: if (idx != 3'd7) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_design_1_wrapper.sv
// Randomized bench for design_1_wrapper against a word-level memory model.
module tb_design_1_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_in;
  logic [3:0]  web;
  logic [31:0] data_out;
  logic [5:0]  DEBUG_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [256];

  design_1_wrapper dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .web(web),
    .data_out(data_out), .DEBUG_state(DEBUG_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // all tasks start and end at posedge+1
  task automatic hwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; data_in = d; web = be;
    @(posedge clk); #1;
    web = 4'h0;
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[a[9:2]][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic hread(input logic [31:0] a, output logic [31:0] d);
    addr = a; web = 4'h0;
    @(posedge clk); #1;
    d = data_out;
  endtask

  task automatic check_words;
    logic [31:0] d;
    for (int w = 0; w < 32; w++) begin
      hread(w * 4, d);
      chk($sformatf("word%0d", w), d, ref_mem[w]);
    end
  endtask

  function automatic void apply_op(input logic [1:0] m);
    logic [31:0] sum = 0;
    for (int i = 0; i < 8; i++) begin
      if (m == 2'd1)      ref_mem[16 + i] = ref_mem[1 + i];
      else if (m == 2'd2) ref_mem[16 + i] = ~ref_mem[1 + i];
      else                sum += ref_mem[1 + i];
    end
    if (m == 2'd0 || m == 2'd3) ref_mem[9] = sum;
    ref_mem[0] = 32'h8000_0000 | (32'(m) << 1);
  endfunction

  // expected state n edges after the start write, with no stalls
  function automatic logic [5:0] exp_state(input int n);
    if (n < 2)   return 6'h01;
    if (n <= 25) begin
      case ((n - 2) % 3)
        0:       return 6'h02;
        1:       return 6'h04;
        default: return 6'h08;
      endcase
    end
    if (n == 26) return 6'h10;
    if (n == 27) return 6'h20;
    return 6'h01;
  endfunction

  task automatic run_op(input logic [1:0] m, input bit timed, input bit disturb);
    int n;
    bit seen_done = 0;
    hwrite(32'h0, {29'd0, m, 1'b1}, 4'hF);
    for (n = 1; n <= 300; n++) begin
      if (disturb && n == 6)
        hwrite(32'h0, {29'd0, m ^ 2'b11, 1'b1}, 4'hF);
      else if (disturb && $urandom_range(0, 3) == 0)
        hwrite(32'($urandom_range(32, 255)) << 2, $urandom, 4'($urandom_range(1, 15)));
      else begin
        @(posedge clk); #1;
      end
      if (timed && n <= 27) chk($sformatf("state_e%0d", n), 32'(DEBUG_state), 32'(exp_state(n)));
      if (DEBUG_state == 6'h20) begin
        seen_done = 1;
        break;
      end
    end
    chk("done_reached", 32'(seen_done), 32'd1);
    if (timed) chk("done_edge", n, 27);
    apply_op(m);
  endtask

  task automatic load_words(input logic [31:0] base, input bit rnd);
    for (int i = 0; i < 8; i++)
      hwrite((1 + i) * 4, rnd ? $urandom : base + i, 4'hF);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  m;
    bit          seen;
    rst = 1'b1; addr = '0; data_in = '0; web = 4'h0;
    #1;
    chk("rst_state", 32'(DEBUG_state), 32'h01);
    chk("rst_dout", data_out, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_hold", 32'(DEBUG_state), 32'h01);
    end

    for (int w = 0; w < 32; w++) hwrite(w * 4, 32'h0, 4'hF);

    hwrite(32'h4, 32'h0000_AB00, 4'b0010);
    hread(32'h404, d);
    chk("byte_alias", d, 32'h0000_AB00);
    hwrite(32'h405, 32'h1234_5678, 4'b1001);
    hread(32'h7, d);
    chk("byte_mix", d, ref_mem[1]);

    load_words(32'd1, 0);
    run_op(2'd0, 1, 0);
    hread(32'h24, d); chk("sum_word9", d, 32'd36);
    hread(32'h0, d);  chk("sum_word0", d, 32'h8000_0000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_retrigger", 32'(DEBUG_state), 32'h01);
    end

    load_words(32'hA0, 0);
    run_op(2'd1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      hread((16 + i) * 4, d);
      chk($sformatf("copy_w%0d", 16 + i), d, 32'hA0 + i);
    end
    hread(32'h0, d); chk("copy_word0", d, 32'h8000_0002);

    hwrite(32'h4, 32'h0, 4'hF);
    run_op(2'd2, 1, 0);
    hread(32'h40, d); chk("inv_word16", d, 32'hFFFF_FFFF);
    check_words();

    for (int t = 0; t < 6; t++) begin
      load_words(0, 1);
      m = 2'($urandom_range(0, 3));
      run_op(m, 0, t[0]);
      check_words();
    end

    // reset in the middle of a write step aborts, then restarts from word 0
    load_words(0, 1);
    m = 2'($urandom_range(0, 3));
    hwrite(32'h0, {29'd0, m, 1'b1}, 4'hF);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (DEBUG_state == 6'h08 && n > 10) begin seen = 1; break; end
    end
    chk("reach_write", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(DEBUG_state), 32'h01);
    chk("async_rst_dout", data_out, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (DEBUG_state == 6'h20) begin seen = 1; break; end
    end
    chk("restart_done", 32'(seen), 32'd1);
    apply_op(m);
    check_words();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
